// File: rtl/serial_subtract_ctrl_if.sv
// Request/response bundle between a requesting datapath and the bit-serial
// subtract controller.
interface serial_subtract_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic             result_ack;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, abort, result_ack,
    input  ready, busy, result_valid, diff, borrow_out
  );

  modport slave (
    input  start, a, b, abort, result_ack,
    output ready, busy, result_valid, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a - b: one subtract cell (two cascaded half-subtract stages)
// reused LSB-first over WIDTH cycles, framed by start/ready and valid/ack.
module serial_subtract_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtract_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  // Shared subtract cell: first half-subtract on a_i/b_i, second folds in br.
  logic d1, b1, d_bit, b2, br_next;
  assign d1      = a_sr[0] ^ b_sr[0];
  assign b1      = ~a_sr[0] & b_sr[0];
  assign d_bit   = d1 ^ br;
  assign b2      = ~d1 & br;
  assign br_next = b1 | b2;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, datapath included, is cleared on reset so a
    // reset mid-operation leaves no stale partial result behind.
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads pre-edge state.
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
          end else begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            br     <= br_next;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              diff_q   <= {d_bit, res_sr[WIDTH-1:1]};
              borrow_q <= br_next;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          if (bus.abort) begin
            state    <= IDLE;
            diff_q   <= '0;
            borrow_q <= 1'b0;
          end else if (bus.result_ack) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready        = (state == IDLE);
  assign bus.busy         = (state == RUN);
  assign bus.result_valid = (state == DONE);
  assign bus.diff         = diff_q;
  assign bus.borrow_out   = borrow_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Directed plus randomized checks of the serial subtract controller against
// a plain-arithmetic reference (a - b mod 2^W, borrow = a < b).
module tb_serial_subtract_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  serial_subtract_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtract_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; expectations come from integer arithmetic only.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall, input bit mid_start, input bit abort_done);
    logic [W-1:0] ed;
    logic         eb;
    ed = av - bv;
    eb = (av < bv);
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("accept_busy", bus.busy, 1);
    check("accept_ready", bus.ready, 0);
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    for (int k = 1; k < W; k++) begin
      if (mid_start && k == 3) begin
        bus.start = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'h00;
      end
      step();
      bus.start = 1'b0;
      check("run_busy", bus.busy, 1);
      check("run_valid", bus.result_valid, 0);
    end
    step();
    check("done_valid", bus.result_valid, 1);
    check("done_busy", bus.busy, 0);
    check("done_diff", bus.diff, ed);
    check("done_borrow", bus.borrow_out, eb);
    if (mid_start) begin
      bus.start = 1'b1;
      bus.a = 8'hFF;
      bus.b = 8'h00;
      step();
      bus.start = 1'b0;
      check("done_start_valid", bus.result_valid, 1);
      check("done_start_diff", bus.diff, ed);
    end
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", bus.result_valid, 1);
      check("stall_diff", bus.diff, ed);
      check("stall_borrow", bus.borrow_out, eb);
    end
    if (abort_done) begin
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_done_ready", bus.ready, 1);
      check("abort_done_valid", bus.result_valid, 0);
      check("abort_done_diff", bus.diff, 0);
      check("abort_done_borrow", bus.borrow_out, 0);
    end else begin
      bus.result_ack = 1'b1;
      step();
      bus.result_ack = 1'b0;
      check("ack_ready", bus.ready, 1);
      check("ack_valid", bus.result_valid, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.abort = 1'b0;
    bus.result_ack = 1'b0;

    // Reset state
    #2;
    check("rst_ready", bus.ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_diff", bus.diff, 0);
    check("rst_borrow", bus.borrow_out, 0);
    step();
    rst_n = 1'b1;
    step();

    // Directed operands; first one also exercises ignored starts and a stall
    run_op(8'h35, 8'h12, 5, 1'b1, 1'b0);
    run_op(8'h12, 8'h35, 0, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 0, 1'b0, 1'b0);
    run_op(8'hAA, 8'hAA, 1, 1'b0, 1'b0);

    // result_ack while idle does nothing
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    check("idle_ack_ready", bus.ready, 1);
    check("idle_ack_busy", bus.busy, 0);
    check("idle_ack_valid", bus.result_valid, 0);

    // Asynchronous reset while bit 4 is being processed
    bus.a = 8'h80;
    bus.b = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.result_valid, 0);
    check("midrst_diff", bus.diff, 0);
    check("midrst_borrow", bus.borrow_out, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      step();
      check("postrst_valid", bus.result_valid, 0);
    end

    // Abort in DONE clears a nonzero result
    run_op(8'h35, 8'h12, 1, 1'b0, 1'b1);

    // Abort in RUN
    bus.a = 8'h35;
    bus.b = 8'h12;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_run_ready", bus.ready, 1);
    check("abort_run_busy", bus.busy, 0);
    check("abort_run_diff", bus.diff, 0);
    for (int k = 0; k < W; k++) begin
      step();
      check("abort_run_novalid", bus.result_valid, 0);
    end

    // Abort beats start in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle_ready", bus.ready, 1);
    check("abort_idle_busy", bus.busy, 0);

    run_op(8'h80, 8'h01, 0, 1'b0, 1'b0);

    // Randomized operands and stall lengths
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
